// File: rtl/bist_pkg.sv
// Shared BIST definitions: LFSR polynomial, chunk salt, mode/state enums.
// Sender and receiver both import this so their pattern streams agree.
package bist_pkg;

  localparam int          LFSR_W     = 32;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] CHUNK_SALT = 32'h9E37_79B9;

  typedef enum logic {
    BIST_LFSR = 1'b0,
    BIST_WALK = 1'b1
  } bist_mode_e;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    TEST  = 2'd1,
    DONE  = 2'd2
  } bist_rx_state_e;

  // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
  function automatic logic [LFSR_W-1:0] bist_lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] nxt;
    nxt = {1'b0, s[LFSR_W-1:1]};
    if (s[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Pattern source shared by bist_sender and bist_diag_receiver: LFSR with salted
// 32-bit chunk expansion, or walking one-hot followed by walking one-cold.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int          TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mode,
  input  logic                     advance,
  output logic [TEST_CHANNELS-1:0] pattern
);

  localparam int IW = $clog2(2 * TEST_CHANNELS + 1);

  logic [LFSR_W-1:0]        r_lfsr;
  logic [IW-1:0]            r_idx;
  bist_mode_e               r_mode;
  logic [31:0]              w_salt;
  logic [TEST_CHANNELS-1:0] w_lfsr_pat;
  logic [TEST_CHANNELS-1:0] w_walk_pat;

  // Generator state: mode is latched only while in reset, then stepped per case.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
      r_idx  <= '0;
      r_mode <= bist_mode_e'(mode);
    end else if (advance) begin
      if (r_mode == BIST_WALK) begin
        r_idx <= r_idx + IW'(1);
      end else begin
        r_lfsr <= bist_lfsr_next(r_lfsr);
      end
    end
  end

  // Chunk k = lfsr ^ (k * salt); the salt keeps channel i and i+32 from aliasing.
  always_comb begin
    w_salt     = '0;
    w_lfsr_pat = '0;
    for (int i = 0; i < TEST_CHANNELS; i++) begin
      w_salt        = 32'(i / 32) * CHUNK_SALT;
      w_lfsr_pat[i] = r_lfsr[i % 32] ^ w_salt[i % 32];
    end
  end

  // First TEST_CHANNELS cases walk a single 1, the next TEST_CHANNELS walk a single 0.
  always_comb begin
    w_walk_pat = '0;
    for (int i = 0; i < TEST_CHANNELS; i++) begin
      if (r_idx < IW'(TEST_CHANNELS)) begin
        w_walk_pat[i] = (r_idx == IW'(i));
      end else begin
        w_walk_pat[i] = (r_idx != IW'(i + TEST_CHANNELS));
      end
    end
  end

  assign pattern = (r_mode == BIST_WALK) ? w_walk_pat : w_lfsr_pat;

endmodule

// File: rtl/bist_diag_receiver.sv
// Link BIST receiver: compares the received link against a local pattern copy,
// builds sticky stuck-high/stuck-low maps and a saturating error count.
module bist_diag_receiver
  import bist_pkg::*;
#(
  parameter int          TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int          TEST_CASES    = 1000,
  parameter int          ALIGN_CYCLES  = 0,
  parameter int          ERR_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mode,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     failed,
  output logic [TEST_CHANNELS-1:0] fault_hi_map,
  output logic [TEST_CHANNELS-1:0] fault_lo_map,
  output logic [ERR_W-1:0]         err_count,
  output logic [TEST_CHANNELS-1:0] output_channels
);

  localparam int MAXC = (TEST_CASES > 2 * TEST_CHANNELS) ? TEST_CASES : 2 * TEST_CHANNELS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int AW   = (ALIGN_CYCLES > 0) ? $clog2(ALIGN_CYCLES + 1) : 1;

  localparam logic [CW-1:0] LAST_LFSR  = CW'(TEST_CASES - 1);
  localparam logic [CW-1:0] LAST_WALK  = CW'(2 * TEST_CHANNELS - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_CYCLES);

  bist_rx_state_e           r_state;
  bist_mode_e               r_mode;
  logic [AW-1:0]            r_align;
  logic [CW-1:0]            r_case;
  logic                     r_busy;
  logic                     r_failed;
  logic [TEST_CHANNELS-1:0] r_hi;
  logic [TEST_CHANNELS-1:0] r_lo;
  logic [ERR_W-1:0]         r_err;

  logic                     w_advance;
  logic                     w_last;
  logic [TEST_CHANNELS-1:0] w_expected;
  logic [TEST_CHANNELS-1:0] w_mism;

  assign w_advance = (r_state == TEST);
  assign w_last    = (r_case == ((r_mode == BIST_WALK) ? LAST_WALK : LAST_LFSR));
  assign w_mism    = input_channels ^ w_expected;

  bist_pattern_gen #(
    .TEST_CHANNELS (TEST_CHANNELS),
    .SEED          (SEED)
  ) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .advance (w_advance),
    .pattern (w_expected)
  );

  // ALIGN -> TEST -> DONE sequencer; the last case is compared on the TEST->DONE edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ALIGN;
      r_mode   <= bist_mode_e'(mode);
      r_align  <= '0;
      r_case   <= '0;
      r_busy   <= 1'b1;
      r_failed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_err    <= '0;
    end else begin
      case (r_state)
        ALIGN: begin
          if (r_align == ALIGN_LAST) begin
            r_state <= TEST;
          end else begin
            r_align <= r_align + AW'(1);
          end
        end
        TEST: begin
          r_hi   <= r_hi | (w_mism & ~w_expected);
          r_lo   <= r_lo | (w_mism & w_expected);
          r_case <= r_case + CW'(1);
          if (|w_mism) begin
            r_failed <= 1'b1;
            if (r_err != {ERR_W{1'b1}}) begin
              r_err <= r_err + ERR_W'(1);
            end
          end
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= ALIGN;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Transparent pass-through once the test is over, quiet link before that.
  always_comb begin
    if (r_state == DONE) begin
      output_channels = input_channels;
    end else begin
      output_channels = '0;
    end
  end

  assign busy         = r_busy;
  assign failed       = r_failed;
  assign fault_hi_map = r_hi;
  assign fault_lo_map = r_lo;
  assign err_count    = r_err;

endmodule

// File: tb/tb_bist_diag_receiver.sv
// Directed bench: four receivers (70/33/1/32 channels) fed by a behavioural sender
// through a fault-injecting link; lane 1 adds a 3-stage link delay.
module tb_bist_diag_receiver;

  localparam logic [31:0] SEED = 32'hdeadbeef;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] SALT = 32'h9e3779b9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n   = 4'b0000;
  logic [3:0]  mode_in = 4'b0000;
  logic        bridge  = 1'b0;
  logic [69:0] fhi [4];
  logic [69:0] flo [4];
  logic [69:0] sender_in [4];

  int errors = 0;
  int checks = 0;

  function automatic int lw(input int j);
    case (j)
      0:       return 70;
      1:       return 33;
      2:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic int ncase(input int j, input logic walk);
    if (walk) return 2 * lw(j);
    case (j)
      0:       return 1000;
      1:       return 40;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int emax(input int j);
    return (j == 1) ? 15 : 65535;
  endfunction

  function automatic logic [69:0] lmask(input int w);
    logic [69:0] ones;
    ones = '1;
    return ones >> (70 - w);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [69:0] gen_pat(input logic [31:0] l, input int idx, input logic walk, input int w);
    logic [95:0] wide;
    if (walk) begin
      if (idx < w) return 70'd1 << idx;
      else         return lmask(w) & ~(70'd1 << (idx - w));
    end
    wide = {l ^ (32'd2 * SALT), l ^ SALT, l};
    return wide[69:0] & lmask(w);
  endfunction

  function automatic logic [69:0] link(input logic [69:0] t, input logic [69:0] hi, input logic [69:0] lo,
                                       input logic br, input int w);
    logic [69:0] r;
    r = t;
    if (br) begin
      r[3] = t[3] | t[4];
      r[4] = t[3] | t[4];
    end
    return ~lo & (hi | r) & lmask(w);
  endfunction

  // Behavioural sender plus reference scoreboard, one lane per receiver
  logic        m_started [4];
  int          m_idx [4];
  logic [31:0] m_lfsr [4];
  logic        m_walk [4];
  logic [69:0] m_hi [4];
  logic [69:0] m_lo [4];
  logic [69:0] m_or [4];
  int          m_err [4];
  logic [69:0] cur_pat [4];
  logic [69:0] tx [4];
  logic [69:0] rx0 [4];

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      cur_pat[j] = gen_pat(m_lfsr[j], m_idx[j], m_walk[j], lw(j));
      tx[j]      = (m_idx[j] < ncase(j, m_walk[j])) ? cur_pat[j] : (sender_in[j] & lmask(lw(j)));
      rx0[j]     = link(tx[j], fhi[j], flo[j], bridge && (j == 0), lw(j));
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (!rst_n[j]) begin
        m_started[j] <= 1'b0;
        m_idx[j]     <= 0;
        m_lfsr[j]    <= SEED;
        m_walk[j]    <= mode_in[j];
        m_hi[j]      <= '0;
        m_lo[j]      <= '0;
        m_or[j]      <= '0;
        m_err[j]     <= 0;
      end else if (!m_started[j]) begin
        m_started[j] <= 1'b1;
      end else if (m_idx[j] < ncase(j, m_walk[j])) begin
        m_idx[j]  <= m_idx[j] + 1;
        m_lfsr[j] <= lfsr_step(m_lfsr[j]);
        m_or[j]   <= m_or[j] | cur_pat[j];
        m_hi[j]   <= m_hi[j] | ((rx0[j] ^ cur_pat[j]) & ~cur_pat[j]);
        m_lo[j]   <= m_lo[j] | ((rx0[j] ^ cur_pat[j]) & cur_pat[j]);
        if (rx0[j] != cur_pat[j] && m_err[j] < emax(j)) m_err[j] <= m_err[j] + 1;
      end
    end
  end

  logic [32:0] d1, d2, d3;
  always @(posedge clk) begin
    d1 <= rx0[1][32:0];
    d2 <= d1;
    d3 <= d2;
  end

  logic [3:0]  busy_w, fail_w;
  logic [69:0] hi_w [4];
  logic [69:0] lo_w [4];
  logic [69:0] out_w [4];
  logic [15:0] err_w [4];

  logic [69:0] hi_a, lo_a, out_a;
  logic [32:0] hi_b, lo_b, out_b;
  logic [0:0]  hi_c, lo_c, out_c;
  logic [31:0] hi_d, lo_d, out_d;
  logic [15:0] err_a, err_c, err_d;
  logic [3:0]  err_b;

  bist_diag_receiver #(.TEST_CHANNELS(70), .SEED(SEED), .TEST_CASES(1000), .ALIGN_CYCLES(0), .ERR_W(16)) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .mode(mode_in[0]), .input_channels(rx0[0]),
    .busy(busy_w[0]), .failed(fail_w[0]), .fault_hi_map(hi_a), .fault_lo_map(lo_a),
    .err_count(err_a), .output_channels(out_a));

  bist_diag_receiver #(.TEST_CHANNELS(33), .SEED(SEED), .TEST_CASES(40), .ALIGN_CYCLES(3), .ERR_W(4)) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .mode(mode_in[1]), .input_channels(d3),
    .busy(busy_w[1]), .failed(fail_w[1]), .fault_hi_map(hi_b), .fault_lo_map(lo_b),
    .err_count(err_b), .output_channels(out_b));

  bist_diag_receiver #(.TEST_CHANNELS(1), .SEED(SEED), .TEST_CASES(8), .ALIGN_CYCLES(0), .ERR_W(16)) dut_c (
    .clk(clk), .reset_n(rst_n[2]), .mode(mode_in[2]), .input_channels(rx0[2][0:0]),
    .busy(busy_w[2]), .failed(fail_w[2]), .fault_hi_map(hi_c), .fault_lo_map(lo_c),
    .err_count(err_c), .output_channels(out_c));

  bist_diag_receiver #(.TEST_CHANNELS(32), .SEED(SEED), .TEST_CASES(16), .ALIGN_CYCLES(0), .ERR_W(16)) dut_d (
    .clk(clk), .reset_n(rst_n[3]), .mode(mode_in[3]), .input_channels(rx0[3][31:0]),
    .busy(busy_w[3]), .failed(fail_w[3]), .fault_hi_map(hi_d), .fault_lo_map(lo_d),
    .err_count(err_d), .output_channels(out_d));

  assign hi_w[0] = hi_a;         assign lo_w[0] = lo_a;         assign out_w[0] = out_a;
  assign hi_w[1] = 70'(hi_b);    assign lo_w[1] = 70'(lo_b);    assign out_w[1] = 70'(out_b);
  assign hi_w[2] = 70'(hi_c);    assign lo_w[2] = 70'(lo_c);    assign out_w[2] = 70'(out_c);
  assign hi_w[3] = 70'(hi_d);    assign lo_w[3] = 70'(lo_d);    assign out_w[3] = 70'(out_d);
  assign err_w[0] = err_a;       assign err_w[1] = 16'(err_b);
  assign err_w[2] = err_c;       assign err_w[3] = err_d;

  // Reset lane j, release it, flip mode (must be ignored) and count busy cycles.
  task automatic run_lane(input int j, input int budget, output int cycles, output logic out_leak);
    @(negedge clk);
    rst_n[j] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[j]   = 1'b1;
    mode_in[j] = ~mode_in[j];
    cycles     = 0;
    out_leak   = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_w[j]) break;
      cycles++;
      if (out_w[j] != '0) out_leak = 1'b1;
    end
    mode_in[j] = ~mode_in[j];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy_w[0]); end
    checks++; if (busy_w[1] !== 1'b1) begin errors++; $display("FAIL reset_busy_b: got %b want 1", busy_w[1]); end
    checks++; if (fail_w[0] !== 1'b0) begin errors++; $display("FAIL reset_failed: got %b want 0", fail_w[0]); end
    checks++; if (hi_w[0] !== 70'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_w[0]); end
    checks++; if (lo_w[0] !== 70'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_w[0]); end
    checks++; if (err_w[0] !== 16'h0) begin errors++; $display("FAIL reset_err: got %h want 0", err_w[0]); end
    checks++; if (out_w[0] !== 70'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out_w[0]); end
  endtask

  task automatic test_lfsr_clean();
    int cyc; logic leak;
    run_lane(0, 1100, cyc, leak);
    checks++; if (cyc !== 1000) begin errors++; $display("FAIL clean_busy_cycles: got %0d want 1000", cyc); end
    checks++; if (leak !== 1'b0) begin errors++; $display("FAIL clean_out_while_busy: got %b want 0", leak); end
    checks++; if (fail_w[0] !== 1'b0) begin errors++; $display("FAIL clean_failed: got %b want 0", fail_w[0]); end
    checks++; if (hi_w[0] !== 70'h0) begin errors++; $display("FAIL clean_hi: got %h want 0", hi_w[0]); end
    checks++; if (lo_w[0] !== 70'h0) begin errors++; $display("FAIL clean_lo: got %h want 0", lo_w[0]); end
    checks++; if (err_w[0] !== 16'h0) begin errors++; $display("FAIL clean_err: got %h want 0", err_w[0]); end
    sender_in[0] = 70'hcafecafe;
    @(negedge clk);
    checks++; if (out_w[0] !== 70'hcafecafe) begin errors++; $display("FAIL passthrough: got %h want cafecafe", out_w[0]); end
    sender_in[0] = '0;
  endtask

  task automatic test_stuck();
    int cyc; logic leak;
    fhi[0] = 70'h80;
    flo[0] = 70'h02;
    run_lane(0, 1100, cyc, leak);
    checks++; if (cyc !== 1000) begin errors++; $display("FAIL stuck_busy_cycles: got %0d want 1000", cyc); end
    checks++; if (fail_w[0] !== 1'b1) begin errors++; $display("FAIL stuck_failed: got %b want 1", fail_w[0]); end
    checks++; if (hi_w[0] !== 70'h80) begin errors++; $display("FAIL stuck_hi: got %h want 80", hi_w[0]); end
    checks++; if (lo_w[0] !== 70'h02) begin errors++; $display("FAIL stuck_lo: got %h want 02", lo_w[0]); end
    checks++; if (err_w[0] !== 16'(m_err[0]) || err_w[0] == 16'h0)
      begin errors++; $display("FAIL stuck_err: got %0d want %0d (nonzero)", err_w[0], m_err[0]); end
    fhi[0] = '0;
    flo[0] = '0;
  endtask

  task automatic test_walk_bridge();
    int cyc; logic leak;
    mode_in[0] = 1'b1;
    bridge     = 1'b1;
    run_lane(0, 200, cyc, leak);
    checks++; if (cyc !== 140) begin errors++; $display("FAIL walk_busy_cycles: got %0d want 140", cyc); end
    checks++; if (hi_w[0] !== 70'h18) begin errors++; $display("FAIL walk_hi: got %h want 18", hi_w[0]); end
    checks++; if (lo_w[0] !== 70'h0) begin errors++; $display("FAIL walk_lo: got %h want 0", lo_w[0]); end
    checks++; if (err_w[0] !== 16'd4) begin errors++; $display("FAIL walk_err: got %0d want 4", err_w[0]); end
    checks++; if (fail_w[0] !== 1'b1) begin errors++; $display("FAIL walk_failed: got %b want 1", fail_w[0]); end
    mode_in[0] = 1'b0;
    bridge     = 1'b0;
  endtask

  task automatic test_saturate();
    int cyc; logic leak;
    flo[1] = '1;
    run_lane(1, 100, cyc, leak);
    checks++; if (cyc !== 43) begin errors++; $display("FAIL sat_busy_cycles: got %0d want 43", cyc); end
    checks++; if (err_w[1] !== 16'hf) begin errors++; $display("FAIL sat_err: got %h want f", err_w[1]); end
    checks++; if (lo_w[1] !== m_or[1] || m_or[1] == 70'h0)
      begin errors++; $display("FAIL sat_lo: got %h want %h", lo_w[1], m_or[1]); end
    checks++; if (hi_w[1] !== 70'h0) begin errors++; $display("FAIL sat_hi: got %h want 0", hi_w[1]); end
    checks++; if (fail_w[1] !== 1'b1) begin errors++; $display("FAIL sat_failed: got %b want 1", fail_w[1]); end
    flo[1] = '0;
  endtask

  task automatic test_reset_mid();
    int cyc; logic leak;
    @(negedge clk);
    rst_n[0] = 1'b0;
    fhi[0]   = 70'h80;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (500) @(negedge clk);
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy_w[0]); end
    checks++; if (fail_w[0] !== 1'b1) begin errors++; $display("FAIL mid_failed: got %b want 1", fail_w[0]); end
    fhi[0] = '0;
    run_lane(0, 1100, cyc, leak);
    checks++; if (cyc !== 1000) begin errors++; $display("FAIL rerun_busy_cycles: got %0d want 1000", cyc); end
    checks++; if (fail_w[0] !== 1'b0) begin errors++; $display("FAIL rerun_failed: got %b want 0", fail_w[0]); end
    checks++; if (hi_w[0] !== 70'h0) begin errors++; $display("FAIL rerun_hi: got %h want 0", hi_w[0]); end
    checks++; if (lo_w[0] !== 70'h0) begin errors++; $display("FAIL rerun_lo: got %h want 0", lo_w[0]); end
    checks++; if (err_w[0] !== 16'h0) begin errors++; $display("FAIL rerun_err: got %h want 0", err_w[0]); end
  endtask

  task automatic test_widths();
    int cyc; logic leak;
    int exp_cyc;
    logic [69:0] exp_hi, exp_lo;
    for (int j = 1; j < 4; j++) begin
      exp_cyc = (j == 1) ? 43 : ncase(j, 1'b0);
      run_lane(j, exp_cyc + 20, cyc, leak);
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL width%0d_busy_cycles: got %0d want %0d", lw(j), cyc, exp_cyc); end
      checks++; if (fail_w[j] !== 1'b0) begin errors++; $display("FAIL width%0d_failed: got %b want 0", lw(j), fail_w[j]); end
      checks++; if (err_w[j] !== 16'h0) begin errors++; $display("FAIL width%0d_err: got %0d want 0", lw(j), err_w[j]); end
      case (j)
        1:       begin fhi[j] = 70'h1_0000_0000; exp_hi = 70'h1_0000_0000; exp_lo = 70'h0; end
        2:       begin flo[j] = 70'h1;           exp_hi = 70'h0;           exp_lo = 70'h1; end
        default: begin flo[j] = 70'h8000_0000;   exp_hi = 70'h0;           exp_lo = 70'h8000_0000; end
      endcase
      run_lane(j, exp_cyc + 20, cyc, leak);
      checks++; if (hi_w[j] !== exp_hi) begin errors++; $display("FAIL width%0d_locate_hi: got %h want %h", lw(j), hi_w[j], exp_hi); end
      checks++; if (lo_w[j] !== exp_lo) begin errors++; $display("FAIL width%0d_locate_lo: got %h want %h", lw(j), lo_w[j], exp_lo); end
      checks++; if (err_w[j] !== 16'(m_err[j]) || fail_w[j] !== 1'b1)
        begin errors++; $display("FAIL width%0d_locate_err: got %0d/%b want %0d/1", lw(j), err_w[j], fail_w[j], m_err[j]); end
      fhi[j] = '0;
      flo[j] = '0;
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      fhi[j]       = '0;
      flo[j]       = '0;
      sender_in[j] = '0;
    end
    test_reset();
    test_lfsr_clean();
    test_stuck();
    test_walk_bridge();
    test_saturate();
    test_reset_mid();
    test_widths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
